// File: rtl/nps_pkg.sv
// Shared definitions for the nps capture pipeline (nps_inmem / nps_outmem).
package nps_pkg;

  localparam int NPS_DATA_WIDTH = 16;
  localparam int NPS_ADR_WIDTH  = 5;

  // Capture state encoding, shared by both memory stages
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } nps_state_t;

endpackage

// File: rtl/nps_outmem_ram.sv
// Simple dual-port storage for nps_outmem: one write port plus a registered,
// read-first read port. The array itself is never reset.
module nps_outmem_ram
  import nps_pkg::*;
#(
  parameter int DATA_WIDTH = NPS_DATA_WIDTH,
  parameter int ADR_WIDTH  = NPS_ADR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_x,
  input  logic                  we,
  input  logic [ADR_WIDTH-1:0]  wadr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADR_WIDTH-1:0]  radr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADR_WIDTH];

  // Write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[wadr] <= wdata;
  end

  // Registered read; a same-edge write is not visible, so old data is returned
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x)  rdata <= '0;
    else if (re)   rdata <= mem[radr];
  end

endmodule

// File: rtl/nps_outmem.sv
// nps_outmem: captures one frame from the inmem stage into a RAM, reports
// completion, word count, overflow, and (optionally) the sum of stored words.
// Optional feature: define NPS_OUTMEM_SUM_EN to enable the sum accumulator;
// otherwise sum is tied to zero.
module nps_outmem
  import nps_pkg::*;
#(
  parameter int DATA_WIDTH = NPS_DATA_WIDTH,
  parameter int ADR_WIDTH  = NPS_ADR_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset_x,
  input  logic                            vi,
  input  logic                            fi,
  input  logic [DATA_WIDTH-1:0]           datai,
  input  logic                            clear,
  input  logic [ADR_WIDTH-1:0]            cpu_adr,
  input  logic                            cpu_rd,
  output logic [DATA_WIDTH-1:0]           cpu_rdata,
  output logic                            done,
  output logic [ADR_WIDTH:0]              count,
  output logic                            ovf,
  output logic [DATA_WIDTH+ADR_WIDTH-1:0] sum
);

  nps_state_t           state, state_nxt;
  logic [ADR_WIDTH:0]   count_nxt;
  logic                 ovf_nxt;
  logic                 wr_en;
  logic [ADR_WIDTH-1:0] wr_adr;
  logic                 full;

  // The extra count bit is set exactly when every address has been written
  assign full   = count[ADR_WIDTH];
  assign wr_adr = count[ADR_WIDTH-1:0];
  assign done   = (state == DONE);

  // State, word count and sticky overflow registers
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state <= IDLE;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Next-state and write decision; clear overrides any incoming word
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    ovf_nxt   = ovf;
    wr_en     = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vi) begin
            wr_en     = 1'b1;
            count_nxt = (ADR_WIDTH+1)'(1);
            state_nxt = fi ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (vi) begin
            if (full) begin
              ovf_nxt = 1'b1;
            end else begin
              wr_en     = 1'b1;
              count_nxt = count + (ADR_WIDTH+1)'(1);
            end
            if (fi) state_nxt = DONE;
          end
        end
        DONE: begin
          if (vi) ovf_nxt = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

`ifdef NPS_OUTMEM_SUM_EN
  // Running sum of stored words; wide enough for a full frame of maximum values
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x)   sum <= '0;
    else if (clear) sum <= '0;
    else if (wr_en) sum <= sum + {{ADR_WIDTH{1'b0}}, datai};
  end
`else
  assign sum = '0;
`endif

  nps_outmem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADR_WIDTH  (ADR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset_x (reset_x),
    .we      (wr_en),
    .wadr    (wr_adr),
    .wdata   (datai),
    .re      (cpu_rd),
    .radr    (cpu_adr),
    .rdata   (cpu_rdata)
  );

endmodule

// File: doc/nps_outmem.md
NPS_OUTMEM -- requirements
Module: nps_outmem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, data word width.
REQ-002 SHALL have parameter ADR_WIDTH, default 5, capture memory address width; depth is 2**ADR_WIDTH (32).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset_x  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port vi  input  1  upstream data valid, from the inmem stage vo.
REQ-006 SHALL have port fi  input  1  last-word flag, from the inmem stage fo; meaningful only with vi=1.
REQ-007 SHALL have port datai  input  DATA_WIDTH  upstream data, from the inmem stage datao.
REQ-008 SHALL have port clear  input  1  single-cycle pulse re-arming capture.
REQ-009 SHALL have port cpu_adr  input  ADR_WIDTH  CPU read address.
REQ-010 SHALL have port cpu_rd  input  1  CPU read strobe.
REQ-011 SHALL have port cpu_rdata  output  DATA_WIDTH  CPU read data, registered.
REQ-012 SHALL have port done  output  1  frame captured, level.
REQ-013 SHALL have port count  output  ADR_WIDTH+1  number of words stored.
REQ-014 SHALL have port ovf  output  1  sticky overflow/late-data flag.
REQ-015 SHALL have port sum  output  DATA_WIDTH+ADR_WIDTH  unsigned sum of stored words.

Function
REQ-016 SHALL implement states IDLE, CAPTURE, DONE.
REQ-017 IDLE: vi=1 writes datai to mem[0], count->1; next state CAPTURE, or DONE if fi=1.
REQ-018 CAPTURE: each vi=1 cycle writes mem[count], count+1; vi=1 with fi=1 stores the word and goes to DONE.
REQ-019 done SHALL be 1 from the cycle after the fi word is written until clear or reset.
REQ-020 fi with vi=0 SHALL be ignored.
REQ-021 Full: vi=1 while count==2**ADR_WIDTH (not DONE) SHALL drop the word, set ovf, leave count at 32, and stay in CAPTURE; fi on a dropped word still moves to DONE.
REQ-022 DONE: vi=1 SHALL not write memory and SHALL set ovf.
REQ-023 clear SHALL return to IDLE next cycle with count=0, done=0, ovf=0, sum=0; memory contents are kept.
REQ-024 clear and vi in the same cycle: clear wins; the word is dropped.
REQ-025 cpu_rd=1 SHALL load cpu_rdata with mem[cpu_adr] on the next edge (1-cycle latency); cpu_rdata holds when cpu_rd=0.
REQ-026 CPU read and capture write to the same address in the same cycle SHALL return the old data (read-first).
REQ-027 sum SHALL add each stored (not dropped) word zero-extended; width DATA_WIDTH+ADR_WIDTH cannot overflow.

Reset
REQ-028 reset_x=0 SHALL asynchronously force IDLE, count=0, done=0, ovf=0, sum=0, cpu_rdata=0; memory is not cleared.
REQ-029 Reset mid-capture SHALL abandon the frame; the next frame starts at address 0.

Configuration
REQ-030 With macro NPS_OUTMEM_SUM_EN defined, sum SHALL behave per REQ-027.
REQ-031 Without NPS_OUTMEM_SUM_EN, the sum port SHALL remain and be tied to 0, with no accumulator logic.

Structure
REQ-032 Package nps_pkg SHALL hold DATA_WIDTH/ADR_WIDTH defaults and the state encoding (IDLE=0, CAPTURE=1, DONE=2), shared with nps_inmem.
REQ-033 Storage SHALL be sub-module nps_outmem_ram: a 2**ADR_WIDTH x DATA_WIDTH simple dual-port RAM with one write port and a registered read-first read port.

Verification
REQ-034 Stream 0..29 with fi on 29 -> done=1 one cycle after the last word, count=30, ovf=0, sum=435; read adr 7 -> cpu_rdata=7 next cycle.
REQ-035 Stream 0..33 with no fi -> count=32, ovf=1, mem[31]=31, done=0; then vi+fi with 99 -> done=1, mem unchanged.
REQ-036 After done, one vi with datai=0xFFFF -> ovf=1, count unchanged, sum unchanged.
REQ-037 clear coincident with vi (datai=5) after 3 words -> count=0, done=0, ovf=0, sum=0, state IDLE.
REQ-038 reset_x low for 2 cycles after 10 words -> all outputs 0; a new 4-word frame 10,11,12,13 -> mem[0..3]=10..13, count=4.
REQ-039 Single vi+fi in IDLE with datai=0x1234 -> done=1, count=1, sum=0x1234 (0 without NPS_OUTMEM_SUM_EN).
